// File: rtl/graph_launcher_if.sv
// Handshake and data bundle between graph_launcher, its host and the graph it launches.
// master = launcher side, slave = host/graph side.
interface graph_launcher_if #(
    parameter int W = 32
);
    logic         job_valid;
    logic         job_ready;
    logic [W-1:0] job_rts;
    logic [W-1:0] job_x1;
    logic [W-1:0] job_xh;

    logic         start_in;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] rts_dout;
    logic [W-1:0] x1_dout;
    logic [W-1:0] xh_dout;

    logic [W-1:0] end_out;
    logic         end_valid;
    logic         end_ready;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_timeout;
    logic [15:0]  res_cycles;
    logic         busy;

    modport master (
        input  job_valid, job_rts, job_x1, job_xh,
        output job_ready,
        output start_in, start_valid, rts_dout, x1_dout, xh_dout,
        input  start_ready,
        input  end_out, end_valid,
        output end_ready,
        output res_valid, res_data, res_timeout, res_cycles, busy,
        input  res_ready
    );

    modport slave (
        output job_valid, job_rts, job_x1, job_xh,
        input  job_ready,
        input  start_in, start_valid, rts_dout, x1_dout, xh_dout,
        output start_ready,
        output end_out, end_valid,
        input  end_ready,
        input  res_valid, res_data, res_timeout, res_cycles, busy,
        output res_ready
    );
endinterface

// File: rtl/graph_launcher.sv
// Accepts one job, launches the graph with its arguments, waits for the result and hands it to the host.
// Optional WAIT timeout enabled by defining GRAPH_LAUNCHER_TIMEOUT_EN.
module graph_launcher #(
    parameter int W              = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    graph_launcher_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] rts_q;
    logic [W-1:0] x1_q;
    logic [W-1:0] xh_q;
    logic [W-1:0] res_data_q;
    logic         res_timeout_q;
    logic [15:0]  res_cycles_q;
    logic [15:0]  cyc_next;
    logic         tmo_en;
    logic         tmo_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef GRAPH_LAUNCHER_TIMEOUT_EN
    assign tmo_en = 1'b1;
`else
    assign tmo_en = 1'b0;
`endif

    // cyc_next is the WAIT cycle count including the current cycle
    assign cyc_next = sat_inc(res_cycles_q);
    assign tmo_hit  = tmo_en && (int'(cyc_next) >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.job_valid)                 state_d = ST_LAUNCH;
            ST_LAUNCH: if (bus.start_ready)               state_d = ST_WAIT;
            ST_WAIT:   if (bus.end_valid || tmo_hit)      state_d = ST_DONE;
            ST_DONE:   if (bus.res_ready)                 state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rts_q         <= '0;
            x1_q          <= '0;
            xh_q          <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            res_cycles_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.job_valid) begin
                rts_q        <= bus.job_rts;
                x1_q         <= bus.job_x1;
                xh_q         <= bus.job_xh;
                res_cycles_q <= '0;
            end
            // a result arriving on the timeout cycle takes priority over the timeout
            if (state_q == ST_WAIT) begin
                res_cycles_q <= cyc_next;
                if (bus.end_valid) begin
                    res_data_q    <= bus.end_out;
                    res_timeout_q <= 1'b0;
                end else if (tmo_hit) begin
                    res_data_q    <= '0;
                    res_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.job_ready   = (state_q == ST_IDLE);
    assign bus.start_valid = (state_q == ST_LAUNCH);
    assign bus.start_in    = (state_q == ST_LAUNCH);
    assign bus.end_ready   = (state_q == ST_WAIT);
    assign bus.res_valid   = (state_q == ST_DONE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rts_dout    = rts_q;
    assign bus.x1_dout     = x1_q;
    assign bus.xh_dout     = xh_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_timeout = res_timeout_q & tmo_en;
    assign bus.res_cycles  = res_cycles_q;
endmodule

// File: tb/tb_graph_launcher.sv
// Self-checking bench for graph_launcher: directed job table, random jobs against a result model,
// and hand-written reset sequences. Honours GRAPH_LAUNCHER_TIMEOUT_EN like the design.
module tb_graph_launcher;
    localparam int W   = 32;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    string cur = "";

    graph_launcher_if #(.W(W)) bus ();

    graph_launcher #(.W(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rts, x1, xh;
        int           sdly;   // cycles start_ready held low in LAUNCH
        int           edly;   // WAIT cycle on which end_valid is driven
        logic [W-1:0] eo;
        int           rdly;   // cycles res_ready held low in DONE
        logic [W-1:0] exp_data;
        logic         exp_to;
        int           exp_cyc;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", cur, name, act, exp, $time);
        end
    endtask

    // Result the host should see for a job whose graph answers on WAIT cycle edly.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   timed_out = 1'b0;
`ifdef GRAPH_LAUNCHER_TIMEOUT_EN
        timed_out = (v.edly > TMO);
`endif
        r.exp_to   = timed_out;
        r.exp_data = timed_out ? '0 : v.eo;
        r.exp_cyc  = timed_out ? TMO : v.edly;
        return r;
    endfunction

    task automatic chk_dout(input vec_t v);
        chk("rts_dout", bus.rts_dout, v.rts);
        chk("x1_dout",  bus.x1_dout,  v.x1);
        chk("xh_dout",  bus.xh_dout,  v.xh);
    endtask

    task automatic do_job(input vec_t v);
        chk("idle_job_ready", bus.job_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_start_valid", bus.start_valid, 0);
        bus.job_valid = 1'b1;
        bus.job_rts = v.rts; bus.job_x1 = v.x1; bus.job_xh = v.xh;
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        bus.job_rts = ~v.rts; bus.job_x1 = ~v.x1; bus.job_xh = ~v.xh;
        for (int i = 0; i <= v.sdly; i++) begin
            chk("launch_start_valid", bus.start_valid, 1);
            chk("launch_start_in", bus.start_in, 1);
            chk("launch_job_ready", bus.job_ready, 0);
            chk("launch_end_ready", bus.end_ready, 0);
            chk("launch_busy", bus.busy, 1);
            chk_dout(v);
            bus.end_valid   = 1'b1;
            bus.end_out     = 32'hBAD0BAD0;
            bus.start_ready = (i == v.sdly);
            @(posedge clk); #1;
        end
        bus.start_ready = 1'b0;
        bus.end_valid   = 1'b0;
        for (int k = 1; k <= v.exp_cyc; k++) begin
            chk("wait_end_ready", bus.end_ready, 1);
            chk("wait_start_valid", bus.start_valid, 0);
            chk("wait_res_valid", bus.res_valid, 0);
            chk_dout(v);
            bus.end_valid = (k == v.edly);
            bus.end_out   = v.eo;
            @(posedge clk); #1;
        end
        bus.end_valid = 1'b0;
        for (int r = 0; r <= v.rdly; r++) begin
            chk("done_res_valid", bus.res_valid, 1);
            chk("done_res_data", bus.res_data, v.exp_data);
            chk("done_res_timeout", bus.res_timeout, v.exp_to);
            chk("done_res_cycles", bus.res_cycles, v.exp_cyc);
            chk("done_job_ready", bus.job_ready, 0);
            chk("done_end_ready", bus.end_ready, 0);
            chk_dout(v);
            bus.end_valid = 1'b1;
            bus.end_out   = 32'hBAD00000 | r;
            bus.res_ready = (r == v.rdly);
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b0;
        bus.end_valid = 1'b0;
        chk("post_res_valid", bus.res_valid, 0);
        chk("post_job_ready", bus.job_ready, 1);
    endtask

    vec_t table_v[5];
    vec_t v;

    initial begin
        rst_n           = 1'b0;
        bus.job_valid   = 1'b0;
        bus.job_rts     = '0; bus.job_x1 = '0; bus.job_xh = '0;
        bus.start_ready = 1'b0;
        bus.end_out     = '0;
        bus.end_valid   = 1'b0;
        bus.res_ready   = 1'b0;

        table_v[0] = '{32'd11, 32'd11, 32'd11, 0, 7, 32'h5, 0, 32'h5, 1'b0, 7};
        table_v[1] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 4, 3, 32'h1234, 0, 32'h1234, 1'b0, 3};
        table_v[2] = '{32'h1, 32'h2, 32'h3, 1, 16, 32'hA, 1, 32'hA, 1'b0, 16};
        table_v[3] = '{32'hCAFE0001, 32'h0, 32'h7FFFFFFF, 0, 2, 32'hDEADBEEF, 10, 32'hDEADBEEF, 1'b0, 2};
        table_v[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h55AA55AA, 2, 1, 32'hFFFFFFFF, 3, 32'hFFFFFFFF, 1'b0, 1};

        // reset state while rst is held low
        cur = "reset";
        repeat (3) @(posedge clk);
        #1;
        chk("job_ready", bus.job_ready, 1);
        chk("start_valid", bus.start_valid, 0);
        chk("start_in", bus.start_in, 0);
        chk("end_ready", bus.end_ready, 0);
        chk("res_valid", bus.res_valid, 0);
        chk("res_timeout", bus.res_timeout, 0);
        chk("busy", bus.busy, 0);
        chk("res_data", bus.res_data, 0);
        chk("res_cycles", bus.res_cycles, 0);
        chk("rts_dout", bus.rts_dout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            cur = $sformatf("table%0d", i);
            do_job(table_v[i]);
        end

        // graph that answers late: timeout when enabled, otherwise a normal long wait
        cur = "late";
        v = '{32'h10, 32'h20, 32'h30, 0, 40, 32'h77, 2, '0, 1'b0, 0};
        do_job(model(v));
        cur = "late_idle";
        bus.end_valid = 1'b1;
        bus.end_out   = 32'h99;
        @(posedge clk); #1;
        chk("res_valid", bus.res_valid, 0);
        chk("job_ready", bus.job_ready, 1);
        bus.end_valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cur = $sformatf("rand%0d", i);
            v.rts  = $urandom; v.x1 = $urandom; v.xh = $urandom;
            v.sdly = $urandom_range(0, 3);
            v.edly = $urandom_range(1, 24);
            v.eo   = $urandom;
            v.rdly = $urandom_range(0, 3);
            do_job(model(v));
        end

        // reset in the middle of WAIT aborts the job
        cur = "midwait_rst";
        bus.job_valid = 1'b1;
        bus.job_rts = 32'h5; bus.job_x1 = 32'h6; bus.job_xh = 32'h7;
        @(posedge clk); #1;
        bus.job_valid   = 1'b0;
        bus.start_ready = 1'b1;
        @(posedge clk); #1;
        bus.start_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_wait", bus.end_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("job_ready", bus.job_ready, 1);
        chk("busy", bus.busy, 0);
        chk("end_ready", bus.end_ready, 0);
        chk("res_valid", bus.res_valid, 0);
        chk("rts_dout", bus.rts_dout, 0);
        chk("res_cycles", bus.res_cycles, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.end_valid = 1'b1;
        bus.end_out   = 32'h3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("after_res_valid", bus.res_valid, 0);
            chk("after_job_ready", bus.job_ready, 1);
        end
        bus.end_valid = 1'b0;

        cur = "after_rst_job";
        v = '{32'h21, 32'h22, 32'h23, 1, 5, 32'hFACE, 1, '0, 1'b0, 0};
        do_job(model(v));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/graph_launcher.md
GRAPH_LAUNCHER -- requirements
Module: graph_launcher

Interface
REQ-001 SHALL have parameter W, default 32: argument and result data width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for end_valid after start is accepted.
REQ-003 SHALL have port clk  input  1: the only clock; one clock domain.
REQ-004 SHALL have port rst  input  1: reset is asynchronous and active-low (asserted at 0).
REQ-005 SHALL have ports job_valid  input  1 and job_ready  output  1: job request handshake.
REQ-006 SHALL have ports job_rts, job_x1, job_xh  input  W: job arguments.
REQ-007 SHALL have ports start_in  output  1, start_valid  output  1, start_ready  input  1: graph start token.
REQ-008 SHALL have ports rts_dout, x1_dout, xh_dout  output  W: arguments driven to the graph.
REQ-009 SHALL have ports end_out  input  W, end_valid  input  1, end_ready  output  1: graph result.
REQ-010 SHALL have ports res_valid  output  1, res_ready  input  1, res_data  output  W: result handshake to the host.
REQ-011 SHALL have ports res_timeout  output  1 and res_cycles  output  16: result status.
REQ-012 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> LAUNCH -> WAIT -> DONE -> IDLE; no other transitions except reset.
REQ-014 IDLE: SHALL drive job_ready=1; when job_valid=1, SHALL register all three arguments and move to LAUNCH.
REQ-015 LAUNCH: SHALL drive start_valid=1 and start_in=1 from the cycle after job acceptance; on start_ready=1, SHALL move to WAIT.
REQ-016 SHALL hold rts_dout/x1_dout/xh_dout stable at the registered values from LAUNCH entry until DONE exits.
REQ-017 WAIT: SHALL drive end_ready=1; on end_valid=1, SHALL capture end_out into res_data with res_timeout=0 and move to DONE.
REQ-018 end_ready SHALL be 0 outside WAIT; end_valid in any other state SHALL be ignored.
REQ-019 res_cycles SHALL count cycles spent in WAIT (first WAIT cycle = 1), saturating at 16'hFFFF.
REQ-020 DONE: SHALL drive res_valid=1, with res_data, res_timeout and res_cycles held stable; on res_ready=1, SHALL move to IDLE.
REQ-021 job_ready SHALL be 0 outside IDLE; back-to-back jobs SHALL take at least one IDLE cycle between them.
REQ-022 All outputs SHALL be registered or decoded from the state register only; there SHALL be no combinational path from any input to any output.

Reset
REQ-023 While rst=0, SHALL be in IDLE with start_valid, start_in, end_ready, res_valid, res_timeout and busy at 0, job_ready at 1, and data outputs and res_cycles at 0.
REQ-024 Reset asserted in any state SHALL abort the job immediately with no res_valid pulse; after release, SHALL resume from IDLE.

Configuration
REQ-025 SHALL provide macro GRAPH_LAUNCHER_TIMEOUT_EN.
- Defined: in WAIT, when res_cycles reaches TIMEOUT_CYCLES without end_valid, SHALL move to DONE with res_timeout=1 and res_data=0.
- Defined, with end_valid in that same cycle: the result SHALL win and res_timeout SHALL be 0.
- Not defined: WAIT SHALL last until end_valid, and res_timeout SHALL be tied to 0.

Verification
REQ-026 Job rts=11, x1=11, xh=11; stub returns end_out=32'h5 after 7 WAIT cycles -> start_valid rises one cycle after job accept, res_data=5, res_cycles=7, res_timeout=0.
REQ-027 Job rts=-7, x1=-7, xh=-7; start_ready held 0 for 4 cycles -> start_valid stays high for 5 cycles, dout stays 32'hFFFFFFF9, no WAIT entry early.
REQ-028 Macro defined, TIMEOUT_CYCLES=16, stub never responds -> DONE after 16 WAIT cycles, res_timeout=1, res_data=0; end_valid arriving later is ignored.
REQ-029 Macro defined, end_valid arrives exactly on WAIT cycle 16 with end_out=32'hA -> res_data=A, res_timeout=0.
REQ-030 res_ready held 0 for 10 cycles in DONE -> res_valid and data stable, job_ready=0; rst pulsed low mid-WAIT on a second job -> IDLE next cycle, no res_valid.
